// File: rtl/vga_fb_reader.sv
// Display-side framebuffer reader: 2x upscale of a FB_WxFB_H RGB444 buffer onto VGA timing.
// Define VGA_FB_BORDER_EN to paint a white one-pixel border around the active display.
module vga_fb_reader #(
  parameter int unsigned FB_W   = 320,
  parameter int unsigned FB_H   = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              i_clk25m,
  input  logic              i_rstn_clk25m,
  input  logic [9:0]        i_VGA_x,
  input  logic [9:0]        i_VGA_y,
  input  logic              i_VGA_video,
  input  logic              i_VGA_hsync,
  input  logic              i_VGA_vsync,
  output logic [ADDR_W-1:0] o_fb_raddr,
  output logic              o_fb_ren,
  input  logic [11:0]       i_fb_rdata,
  output logic              o_VGA_hsync,
  output logic              o_VGA_vsync,
  output logic              o_VGA_video,
  output logic [3:0]        o_VGA_red,
  output logic [3:0]        o_VGA_green,
  output logic [3:0]        o_VGA_blue
);

  localparam int unsigned LAT = RD_LAT + 2;
  localparam logic [9:0] DISP_W = 10'(2 * FB_W);
  localparam logic [9:0] DISP_H = 10'(2 * FB_H);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W);

  typedef enum logic {SYNC_WAIT, RUN} state_e;

  state_e              r_state, w_state_next;
  logic                w_sof, w_run, w_ren, w_video_fall, w_force_white;
  logic [ADDR_W-1:0]   r_fb_raddr, r_line_base, w_line_base;
  logic                r_fb_ren, r_video_q;
  logic [9:0]          r_y_act;
  logic [LAT-1:0]      r_hs_sr, r_vs_sr, r_vid_sr;
  logic [LAT-2:0]      r_vld_sr;
  logic [11:0]         r_rgb, w_rgb_next;

  assign w_sof = i_VGA_video && (i_VGA_x == '0) && (i_VGA_y == '0);

  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m) r_state <= SYNC_WAIT;
    else                r_state <= w_state_next;
  end

  // w_run also covers the start-of-frame cycle so address 0 issues on entry.
  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    case (r_state)
      SYNC_WAIT: begin
        if (w_sof) begin
          w_state_next = RUN;
          w_run        = 1'b1;
        end
      end
      RUN:     w_run = 1'b1;
      default: w_state_next = SYNC_WAIT;
    endcase
  end

  assign w_ren        = w_run && i_VGA_video && (i_VGA_x < DISP_W) && (i_VGA_y < DISP_H);
  assign w_line_base  = w_sof ? '0 : r_line_base;
  assign w_video_fall = r_video_q && !i_VGA_video;

  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m) begin
      r_fb_raddr  <= '0;
      r_fb_ren    <= 1'b0;
      r_line_base <= '0;
      r_video_q   <= 1'b0;
      r_y_act     <= '0;
    end else begin
      r_fb_ren  <= w_ren;
      if (w_ren) r_fb_raddr <= w_line_base + ADDR_W'(i_VGA_x[9:1]);
      r_video_q <= i_VGA_video;
      if (i_VGA_video) r_y_act <= i_VGA_y;
      // Each framebuffer row is shown on two display lines; advance after the odd one.
      if (w_sof) begin
        r_line_base <= '0;
      end else if (r_state == RUN && w_video_fall && r_y_act[0]) begin
        if (r_y_act == DISP_H - 10'd1) r_line_base <= '0;
        else                           r_line_base <= r_line_base + LINE_STEP;
      end
    end
  end

  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m) begin
      r_hs_sr  <= '1;
      r_vs_sr  <= '1;
      r_vid_sr <= '0;
      r_vld_sr <= '0;
      r_rgb    <= '0;
    end else begin
      r_hs_sr  <= {r_hs_sr[LAT-2:0], i_VGA_hsync};
      r_vs_sr  <= {r_vs_sr[LAT-2:0], i_VGA_vsync};
      r_vid_sr <= {r_vid_sr[LAT-2:0], i_VGA_video};
      r_vld_sr <= {r_vld_sr[LAT-3:0], w_ren};
      r_rgb    <= w_rgb_next;
    end
  end

`ifdef VGA_FB_BORDER_EN
  logic           w_border;
  logic [LAT-2:0] r_bdr_sr;

  assign w_border = w_run && i_VGA_video &&
                    ((i_VGA_x == '0) || (i_VGA_x == DISP_W - 10'd1) ||
                     (i_VGA_y == '0) || (i_VGA_y == DISP_H - 10'd1));

  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m) r_bdr_sr <= '0;
    else                r_bdr_sr <= {r_bdr_sr[LAT-3:0], w_border};
  end

  assign w_force_white = r_bdr_sr[LAT-2];
`else
  assign w_force_white = 1'b0;
`endif

  // Stage LAT-2 lines up with the cycle in which i_fb_rdata is valid.
  always_comb begin
    w_rgb_next = '0;
    if (r_vid_sr[LAT-2] && r_vld_sr[LAT-2]) w_rgb_next = i_fb_rdata;
    if (w_force_white) w_rgb_next = 12'hFFF;
  end

  assign o_fb_raddr  = r_fb_raddr;
  assign o_fb_ren    = r_fb_ren;
  assign o_VGA_hsync = r_hs_sr[LAT-1];
  assign o_VGA_vsync = r_vs_sr[LAT-1];
  assign o_VGA_video = r_vid_sr[LAT-1];
  assign o_VGA_red   = r_rgb[11:8];
  assign o_VGA_green = r_rgb[7:4];
  assign o_VGA_blue  = r_rgb[3:0];

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Display-side framebuffer reader sitting directly downstream of the VGA timing generator. Takes the generator's pixel coordinates, active-video flag and syncs, issues reads into a 320x240 RGB444 framebuffer written by the camera path, and upscales 2x to fill 640x480. Delays syncs and video to match memory latency so the VGA pins receive aligned colour and timing.

## Interface
- FB_W, 320, framebuffer width in pixels; display width = 2*FB_W
- FB_H, 240, framebuffer height in lines; display height = 2*FB_H
- ADDR_W, 17, framebuffer read address width
- RD_LAT, 2, framebuffer read latency in cycles (legal 1..4)

- i_clk25m  in  1  25 MHz pixel clock; only clock
- i_rstn_clk25m  in  1  reset, asynchronous, active-low
- i_VGA_x  in  10  horizontal pixel counter from timing generator
- i_VGA_y  in  10  vertical line counter from timing generator
- i_VGA_video  in  1  active-video flag
- i_VGA_hsync  in  1  horizontal sync (active-low)
- i_VGA_vsync  in  1  vertical sync (active-low)
- o_fb_raddr  out  ADDR_W  framebuffer read address
- o_fb_ren  out  1  framebuffer read enable
- i_fb_rdata  in  12  read data {R[11:8],G[7:4],B[3:0]}, valid RD_LAT cycles after o_fb_ren
- o_VGA_hsync  out  1  delayed hsync
- o_VGA_vsync  out  1  delayed vsync
- o_VGA_video  out  1  delayed active-video
- o_VGA_red / o_VGA_green / o_VGA_blue  out  4 each  pixel colour

## Operation
- FSM: SYNC_WAIT, RUN.
  - SYNC_WAIT (reset state): o_fb_ren=0, RGB forced 0; syncs/video still pass through the delay line. Exit to RUN when i_VGA_video=1 with x=0, y=0 (start of frame), same cycle issuing address 0.
  - RUN: stays until reset.
- Address: o_fb_raddr = (y>>1)*FB_W + (x>>1). Built with counters, no multiplier: line_base cleared at start of frame; line_base += FB_W after each line with odd y (on video falling edge); column part = x>>1.
- o_fb_ren=1 only in RUN with i_VGA_video=1, x<2*FB_W, y<2*FB_H. Otherwise ren=0 and o_fb_raddr holds last value.
- Pixel tagged valid only if ren was issued for it; unissued active pixels output black.
- Output colour: delayed video=1 and pixel valid -> R=rdata[11:8], G=rdata[7:4], B=rdata[3:0]; else all 0.
- Reset mid-frame: all state cleared, back to SYNC_WAIT; first colour output only after next start of frame.

## Timing
- Input sample at cycle T -> o_fb_raddr/o_fb_ren registered at T+1.
- i_fb_rdata valid at T+1+RD_LAT; captured into output registers -> RGB at T+2+RD_LAT.
- hsync/vsync/video delayed by L = RD_LAT+2 cycles through shift registers; all outputs change on the same edge.
- Reset values: o_fb_raddr=0, o_fb_ren=0, o_VGA_hsync=1, o_VGA_vsync=1, o_VGA_video=0, RGB=0; all delay stages reset to those inactive levels.
- Each framebuffer word read twice consecutively (x even/odd) and on two consecutive lines.
- line_base wraps to 0 at start of frame, never past (FB_H-1)*FB_W.

## Configuration
- VGA_FB_BORDER_EN defined: display pixels with x=0, x=2*FB_W-1, y=0 or y=2*FB_H-1 output 12'hFFF (white) while delayed video=1 in RUN, overriding memory data; reads still issued normally.
- Undefined: memory data shown on every active pixel; no border logic.

## Test plan
- Reset release, generator running, memory returns 12'h000 -> first frame syncs delayed exactly L=4 cycles, RGB 0 until start of frame, ren first rises at x=0,y=0 with addr 0.
- Memory model addr->data = addr[11:0], RD_LAT=2 -> pixel (x=5,y=3) shows 12'h142 (addr 322) at T+4; pixels (4..5, 2..3) share addr 322.
- End of line y=479, x=639 -> addr 76799; next frame x=0,y=0 -> addr 0, ren toggles off in blanking, RGB 0 throughout blanking.
- RD_LAT=1 and RD_LAT=4 builds -> syncs/video/RGB remain mutually aligned; latency L=3 and L=6 respectively.
- Reset asserted mid-line y=200 -> outputs immediately at reset values; after release no colour until next x=0,y=0.
- VGA_FB_BORDER_EN defined, memory returns 12'h00F -> row 0, row 479, column 0, column 639 show 12'hFFF; pixel (1,1) shows 12'h00F.
